// File: rtl/axi4s_fifo.sv
// Synchronous AXI4-Stream FIFO: registered s_tready, one-cycle latency, no fall-through.
// Optional store-and-forward packet mode via `define AXI4S_FIFO_PACKET_MODE_EN.
module axi4s_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_tkeep,
    input  logic [USER_WIDTH-1:0]        s_tuser,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [KEEP_WIDTH-1:0]        m_tkeep,
    output logic [USER_WIDTH-1:0]        m_tuser,
    output logic [$clog2(DEPTH):0]       level
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [BEAT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_d;
    logic              r_s_tready;
    logic              w_accept;
    logic              w_xfer;
    logic              w_m_tvalid;
    logic              w_rd_last;
    logic [BEAT_W-1:0] w_rd_beat;

    assign w_accept = s_tvalid & r_s_tready;
    assign w_xfer   = w_m_tvalid & m_tready;

    always_comb begin
        w_level_d = r_level;
        case ({w_accept, w_xfer})
            2'b10:   w_level_d = r_level + LVL_W'(1);
            2'b01:   w_level_d = r_level - LVL_W'(1);
            default: w_level_d = r_level;
        endcase
    end

    // s_tready is a flop of the next level, so m_tready never reaches it combinationally.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_s_tready <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_xfer)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level    <= w_level_d;
            r_s_tready <= (w_level_d < FULL_LVL);
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_accept) r_mem[r_wr_ptr] <= {s_tdata, s_tkeep, s_tuser, s_tlast};
    end

    assign w_rd_beat = r_mem[r_rd_ptr];
    assign {m_tdata, m_tkeep, m_tuser, w_rd_last} = w_rd_beat;

`ifdef AXI4S_FIFO_PACKET_MODE_EN
    logic [LVL_W-1:0] r_pkt_cnt;
    logic [LVL_W-1:0] w_pkt_cnt_d;
    logic             r_release;
    logic             w_release_d;
    logic             w_full_stall;

    assign w_full_stall = (r_level == FULL_LVL) && (r_pkt_cnt == '0);

    always_comb begin
        w_pkt_cnt_d = r_pkt_cnt;
        case ({w_accept & s_tlast, w_xfer & w_rd_last})
            2'b10:   w_pkt_cnt_d = r_pkt_cnt + LVL_W'(1);
            2'b01:   w_pkt_cnt_d = r_pkt_cnt - LVL_W'(1);
            default: w_pkt_cnt_d = r_pkt_cnt;
        endcase
    end

    // Once an oversize packet fills the FIFO, keep streaming it until its tlast leaves.
    always_comb begin
        w_release_d = r_release;
        if (w_full_stall)          w_release_d = 1'b1;
        if (w_xfer && w_rd_last)   w_release_d = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_pkt_cnt <= '0;
            r_release <= 1'b0;
        end else begin
            r_pkt_cnt <= w_pkt_cnt_d;
            r_release <= w_release_d;
        end
    end

    assign w_m_tvalid = (r_level != '0) &&
                        ((r_pkt_cnt != '0) || r_release || (r_level == FULL_LVL));
`else
    assign w_m_tvalid = (r_level != '0);
`endif

    assign m_tvalid = w_m_tvalid;
    assign m_tlast  = w_m_tvalid & w_rd_last;
    assign s_tready = r_s_tready;
    assign level    = r_level;

endmodule

// File: tb/tb_axi4s_fifo.sv
// Directed self-checking bench for axi4s_fifo (DEPTH=16, DATA_WIDTH=16).
// Packet-mode vectors are compiled in when AXI4S_FIFO_PACKET_MODE_EN is defined.
module tb_axi4s_fifo;

    logic        ACLK;
    logic        ARESETn;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] s_tdata;
    logic [1:0]  s_tkeep;
    logic [0:0]  s_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic [0:0]  m_tuser;
    logic [4:0]  level;

    int n_total;
    int n_bad;

    axi4s_fifo #(
        .DATA_WIDTH (16),
        .USER_WIDTH (1),
        .KEEP_WIDTH (2),
        .DEPTH      (16)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .level    (level)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    logic [15:0] stall_data [3];
    logic [1:0]  stall_keep [3];
    logic [7:0]  rdy_pat;
    int          idx;
    int          wr;
    logic        acc;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        ARESETn  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        m_tready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_s_tready", 32'(s_tready), 0);
        check_eq("rst_m_tvalid", 32'(m_tvalid), 0);
        check_eq("rst_m_tlast", 32'(m_tlast), 0);
        check_eq("rst_level", 32'(level), 0);
        #11 ARESETn = 1'b1;
        step();
        check_eq("post_rst_s_tready", 32'(s_tready), 1);

        // Single beat, one-cycle latency
        s_tvalid = 1'b1; s_tdata = 16'h1234; s_tlast = 1'b1; s_tkeep = 2'b11; m_tready = 1'b1;
        check_eq("no_fallthrough", 32'(m_tvalid), 0);
        step();
        s_tvalid = 1'b0;
        check_eq("one_m_tvalid", 32'(m_tvalid), 1);
        check_eq("one_m_tdata", 32'(m_tdata), 32'h1234);
        check_eq("one_m_tlast", 32'(m_tlast), 1);
        check_eq("one_level1", 32'(level), 1);
        step();
        check_eq("one_level0", 32'(level), 0);
        check_eq("one_empty", 32'(m_tvalid), 0);

        // Fill to DEPTH with the output stalled
        m_tready = 1'b0;
        s_tkeep  = 2'b11;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1; s_tdata = 16'(i); s_tlast = (i == 15);
            step();
        end
        check_eq("full_level", 32'(level), 16);
        check_eq("full_s_tready", 32'(s_tready), 0);
        s_tdata = 16'd16; s_tlast = 1'b1;
        step();
        check_eq("full_hold_level", 32'(level), 16);
        check_eq("full_hold_s_tready", 32'(s_tready), 0);
        m_tready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check_eq("fill_order_valid", 32'(m_tvalid), 1);
            check_eq("fill_order_data", 32'(m_tdata), 32'(k));
            step();
            if (k == 0) begin
                check_eq("unfull_s_tready", 32'(s_tready), 1);
                check_eq("unfull_level", 32'(level), 15);
            end
            if (k == 1) begin
                check_eq("dm1_level", 32'(level), 15);
                s_tvalid = 1'b0;
            end
        end
        check_eq("drain_level", 32'(level), 0);
        check_eq("drain_m_tvalid", 32'(m_tvalid), 0);

        // Continuous streaming: level stays at 1, one beat per cycle
        s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_tdata = 16'(i + 16'h0100);
            step();
            check_eq("stream_level", 32'(level), 1);
            check_eq("stream_valid", 32'(m_tvalid), 1);
            check_eq("stream_data", 32'(m_tdata), 32'(i + 16'h0100));
        end
        s_tvalid = 1'b0;
        step();
        check_eq("stream_end_level", 32'(level), 0);

        // 3-beat packet read out with a stalling m_tready pattern
        stall_data[0] = 16'hA0A0; stall_data[1] = 16'hA1A1; stall_data[2] = 16'hA2A2;
        stall_keep[0] = 2'b11;    stall_keep[1] = 2'b01;    stall_keep[2] = 2'b10;
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = stall_data[i]; s_tkeep = stall_keep[i];
            s_tuser = 1'(i); s_tlast = (i == 2);
            step();
        end
        s_tvalid = 1'b0;
        rdy_pat = 8'b1101_0010;
        idx = 0;
        for (int c = 0; c < 8 && idx < 3; c++) begin
            m_tready = rdy_pat[c];
            check_eq("stall_valid", 32'(m_tvalid), 1);
            check_eq("stall_data", 32'(m_tdata), 32'(stall_data[idx]));
            check_eq("stall_keep", 32'(m_tkeep), 32'(stall_keep[idx]));
            check_eq("stall_user", 32'(m_tuser), 32'(idx % 2));
            check_eq("stall_last", 32'(m_tlast), 32'(idx == 2));
            step();
            if (rdy_pat[c]) idx++;
        end
        check_eq("stall_all_out", 32'(idx), 3);
        check_eq("stall_level", 32'(level), 0);

        // Reset mid-packet with five beats held
        m_tready = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tdata = 16'(16'hDEA0 + i);
            step();
        end
        s_tvalid = 1'b0;
        check_eq("pre_rst_level", 32'(level), 5);
        ARESETn = 1'b0;
        #1;
        check_eq("mid_rst_level", 32'(level), 0);
        check_eq("mid_rst_m_tvalid", 32'(m_tvalid), 0);
        check_eq("mid_rst_s_tready", 32'(s_tready), 0);
        #2 ARESETn = 1'b1;
        step();
        check_eq("re_rst_s_tready", 32'(s_tready), 1);
        s_tvalid = 1'b1; s_tdata = 16'hBEEF; s_tlast = 1'b1; m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        check_eq("re_rst_data", 32'(m_tdata), 32'hBEEF);
        check_eq("re_rst_level", 32'(level), 1);
        step();
        check_eq("re_rst_empty", 32'(level), 0);

`ifdef AXI4S_FIFO_PACKET_MODE_EN
        // Store-and-forward: nothing leaves until tlast is stored
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1; s_tdata = 16'(16'hC000 + i); s_tlast = (i == 3);
            step();
            check_eq("pkt_valid", 32'(m_tvalid), 32'(i == 3));
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("pkt_data", 32'(m_tdata), 32'(16'hC000 + k));
            step();
        end
        check_eq("pkt_level", 32'(level), 0);

        // Oversize 20-beat packet released once the FIFO is full
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1; s_tdata = 16'(i); s_tlast = 1'b0;
            step();
            if (i == 14) check_eq("big_hold_valid", 32'(m_tvalid), 0);
        end
        check_eq("big_full_level", 32'(level), 16);
        check_eq("big_full_valid", 32'(m_tvalid), 1);
        m_tready = 1'b1;
        wr = 16;
        for (int k = 0; k < 20; k++) begin
            check_eq("big_valid", 32'(m_tvalid), 1);
            check_eq("big_data", 32'(m_tdata), 32'(k));
            check_eq("big_last", 32'(m_tlast), 32'(k == 19));
            s_tvalid = (wr < 20); s_tdata = 16'(wr); s_tlast = (wr == 19);
            acc = s_tvalid && s_tready;
            step();
            if (acc) wr++;
        end
        s_tvalid = 1'b0;
        check_eq("big_level", 32'(level), 0);
        check_eq("big_empty", 32'(m_tvalid), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4s_fifo.md
AXI4S_FIFO -- requirements
Module: axi4s_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, TDATA width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter USER_WIDTH, default 1, TUSER width in bits (>=1).
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, TKEEP width in bits.
REQ-004 SHALL have parameter DEPTH, default 16, number of stored beats (power of two, >=2).
REQ-005 SHALL have port ACLK  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port ARESETn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports s_tvalid/s_tready/s_tlast  in/out/in  1 each  slave-side stream handshake and packet end.
REQ-008 SHALL have ports s_tdata/s_tkeep/s_tuser  input  DATA_WIDTH/KEEP_WIDTH/USER_WIDTH  slave-side payload.
REQ-009 SHALL have ports m_tvalid/m_tready/m_tlast  out/in/out  1 each  master-side stream handshake and packet end.
REQ-010 SHALL have ports m_tdata/m_tkeep/m_tuser  output  DATA_WIDTH/KEEP_WIDTH/USER_WIDTH  master-side payload.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  number of beats currently held.

Function
REQ-012 SHALL store each beat as {tdata, tkeep, tuser, tlast} and emit beats in acceptance order, unmodified.
REQ-013 SHALL accept a beat on any rising edge where s_tvalid && s_tready; SHALL transfer a beat out where m_tvalid && m_tready.
REQ-014 SHALL drive s_tready = (level < DEPTH), from registered state only, with no combinational path from m_tready.
REQ-015 SHALL assert m_tvalid in the cycle after the first beat is accepted into an empty FIFO (one-cycle latency); no same-cycle fall-through.
REQ-016 SHALL hold m_tdata/m_tkeep/m_tuser/m_tlast stable while m_tvalid && !m_tready.
REQ-017 SHALL never deassert m_tvalid once asserted until the beat is transferred.
REQ-018 SHALL, on simultaneous accept and transfer, leave level unchanged and lose no beat, including at level 1 and level DEPTH-1.
REQ-019 SHALL, when full, accept nothing; a transfer that cycle makes s_tready high in the following cycle.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without gaps.
REQ-021 SHALL increment level by 1 on accept-only, decrement by 1 on transfer-only, saturating never required (never over/underflows).
REQ-022 SHALL leave m_* payload values don't-care while m_tvalid is low.

Reset
REQ-023 SHALL, on ARESETn low, immediately clear pointers, level, and packet counter, and force s_tready=0, m_tvalid=0, m_tlast=0.
REQ-024 SHALL discard all stored beats on reset, including mid-packet and mid-stall.
REQ-025 SHALL drive s_tready=1 on the first rising edge after ARESETn deasserts.
REQ-026 SHALL not require memory contents to be cleared.

Configuration
REQ-027 SHALL support macro AXI4S_FIFO_PACKET_MODE_EN.
REQ-028 With AXI4S_FIFO_PACKET_MODE_EN defined, SHALL keep a count of complete packets stored (inc on accepted tlast, dec on transferred tlast, both same cycle = no change).
REQ-029 With it defined, SHALL assert m_tvalid only when the packet count is >0, or when level==DEPTH with count 0 (oversize-packet release, prevents deadlock).
REQ-030 Without it, SHALL omit the packet counter; m_tvalid depends on level only (REQ-015).

Verification
REQ-031 Reset, then write beat tdata=0x1234, tlast=1, m_tready=1 -> m_tvalid high next cycle, m_tdata=0x1234, level 1->0 after transfer.
REQ-032 m_tready=0, write 16 beats 0..15 (DEPTH=16) -> level=16, s_tready=0 after the 16th; 17th beat held until one read; readout order 0..15.
REQ-033 Continuous s_tvalid=1, m_tready=1, 100 beats -> one beat per cycle after first, level constant 1, no loss.
REQ-034 m_tready toggled randomly during 3-beat packet -> m_* stable during every stall, tlast only on 3rd beat.
REQ-035 Pulse ARESETn low with level=5 mid-packet -> m_tvalid=0, level=0 immediately; old beats never appear.
REQ-036 PACKET_MODE_EN: write 3 beats without tlast -> m_tvalid stays 0; 4th beat with tlast -> m_tvalid 1 next cycle; 20-beat packet -> released at level 16.
